systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder_pkg.sv | 16 +
 rtl/feeder_buf.sv | 37 +++
 rtl/systolic_feeder.sv | 156 +++++++++++++++
 tb/tb_systolic_feeder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared widths and FSM state codes for the systolic feeder, PE array and output collector.
package systolic_feeder_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned ST_W   = 3;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_FEED  = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/feeder_buf.sv
// ROWS x COLS byte register file: one write port, one combinational read port per row.
module feeder_buf
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  parameter int unsigned RW   = 2,
  parameter int unsigned KW   = 2
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [RW-1:0]            wr_row_i,
  input  logic [KW-1:0]            wr_col_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [ROWS*KW-1:0]       rd_col_i,
  output logic [ROWS*DATA_W-1:0]   rd_data_c
);

  logic [DATA_W-1:0] mem_q [ROWS][COLS];

  // Storage is deliberately unreset so operands survive a reset.
  always_ff @(posedge clk) begin
    if (we_i && (int'(wr_row_i) < int'(ROWS)) && (int'(wr_col_i) < int'(COLS))) begin
      mem_q[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_c = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (int'(rd_col_i[r*KW +: KW]) < int'(COLS)) begin
        rd_data_c[r*DATA_W +: DATA_W] = mem_q[r][rd_col_i[r*KW +: KW]];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Skews A rows and B columns into an N x N systolic array: clear, feed K+N-1 cycles, drain N, done.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter  int unsigned N  = 4,
  parameter  int unsigned K  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned KW = (K > 1) ? $clog2(K) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [IW-1:0]         wr_idx,
  input  logic [KW-1:0]         wr_k,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  acc_clr,
  output logic                  feed_valid,
  output logic [N*DATA_W-1:0]   a_out,
  output logic [N*DATA_W-1:0]   b_out,
  output logic                  done
);

  localparam int unsigned CW = $clog2(K + N);
  localparam logic [CW-1:0] FEED_LAST  = CW'(K + N - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                acc_clr_q, acc_clr_d;
  logic                feed_q, feed_d;
  logic                done_q, done_d;
  logic [N*DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [N*DATA_W-1:0] a_rd_c, b_rd_c;
  logic [N*KW-1:0]     rd_k_c;
  logic [N-1:0]        lane_ok_c;
  logic                we_a_c, we_b_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      acc_clr_q <= 1'b0;
      feed_q    <= 1'b0;
      done_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      acc_clr_q <= acc_clr_d;
      feed_q    <= feed_d;
      done_q    <= done_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

  // One counter serves both FEED and DRAIN; it restarts on entry to each.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_a_c  = 1'b0;
    we_b_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        we_a_c = wr_en && !wr_sel;
        we_b_c = wr_en && wr_sel;
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_FEED;
        cnt_d   = '0;
      end
      ST_FEED: begin
        if (cnt_q == FEED_LAST) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Lane i carries reduction index k = t - i; A rows and B columns share the same skew.
  always_comb begin
    lane_ok_c = '0;
    rd_k_c    = '0;
    for (int i = 0; i < int'(N); i++) begin
      if ((state_d == ST_FEED) && (int'(cnt_d) >= i) && (int'(cnt_d) - i < int'(K))) begin
        lane_ok_c[i]         = 1'b1;
        rd_k_c[i*KW +: KW]   = KW'(int'(cnt_d) - i);
      end
    end
  end

  always_comb begin
    busy_d    = (state_d != ST_IDLE);
    acc_clr_d = (state_d == ST_CLEAR);
    feed_d    = (state_d == ST_FEED);
    done_d    = (state_d == ST_DONE);
    a_d       = '0;
    b_d       = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (lane_ok_c[i]) begin
        a_d[i*DATA_W +: DATA_W] = a_rd_c[i*DATA_W +: DATA_W];
        b_d[i*DATA_W +: DATA_W] = b_rd_c[i*DATA_W +: DATA_W];
      end
    end
  end

  // A is stored as A[i][k]; B is stored transposed as B[k][j] -> row j, column k.
  feeder_buf #(.ROWS(N), .COLS(K), .RW(IW), .KW(KW)) u_buf_a (
    .clk       (clk),
    .we_i      (we_a_c),
    .wr_row_i  (wr_idx),
    .wr_col_i  (wr_k),
    .wr_data_i (wr_data),
    .rd_col_i  (rd_k_c),
    .rd_data_c (a_rd_c)
  );

  feeder_buf #(.ROWS(N), .COLS(K), .RW(IW), .KW(KW)) u_buf_b (
    .clk       (clk),
    .we_i      (we_b_c),
    .wr_row_i  (wr_idx),
    .wr_col_i  (wr_k),
    .wr_data_i (wr_data),
    .rd_col_i  (rd_k_c),
    .rd_data_c (b_rd_c)
  );

  assign busy       = busy_q;
  assign acc_clr    = acc_clr_q;
  assign feed_valid = feed_q;
  assign done       = done_q;
  assign a_out      = a_q;
  assign b_out      = b_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: timeline/operand model, bench-side systolic array, directed sequences.
module tb_systolic_feeder;

  localparam int N       = 4;
  localparam int K       = 4;
  localparam int END_REL = K + 2*N + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
  logic [1:0]     wr_idx = '0, wr_k = '0;
  logic [7:0]     wr_data = '0;
  logic           busy, acc_clr, feed_valid, done;
  logic [N*8-1:0] a_out, b_out;

  systolic_feeder #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_k(wr_k),
    .wr_data(wr_data), .start(start), .busy(busy), .acc_clr(acc_clr),
    .feed_valid(feed_valid), .a_out(a_out), .b_out(b_out), .done(done)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Operand model and sequence position (rel = cycles since accepted start, 0 = idle).
  logic [7:0] am [N][K];
  logic [7:0] bm [K][N];
  int active = 0;
  int rel = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      active = 0;
      rel    = 0;
    end else if (active == 0) begin
      if (wr_en) begin
        if (!wr_sel) am[wr_idx][wr_k] = wr_data;
        else         bm[wr_k][wr_idx] = wr_data;
      end
      if (start) begin
        active = 1;
        rel    = 1;
      end
    end else if (rel == END_REL) begin
      active = 0;
      rel    = 0;
    end else begin
      rel++;
    end
  end

  logic [N*8-1:0] ea, eb;
  int t_m;
  always @(negedge clk) begin
    ea  = '0;
    eb  = '0;
    t_m = rel - 2;
    if (active != 0 && rel >= 2 && rel <= K + N) begin
      for (int i = 0; i < N; i++) begin
        if (t_m - i >= 0 && t_m - i < K) begin
          ea[i*8 +: 8] = am[i][t_m - i];
          eb[i*8 +: 8] = bm[t_m - i][i];
        end
      end
    end
    chk("cmp_busy",  32'(busy),       32'(active != 0));
    chk("cmp_clr",   32'(acc_clr),    32'(active != 0 && rel == 1));
    chk("cmp_feed",  32'(feed_valid), 32'(active != 0 && rel >= 2 && rel <= K + N));
    chk("cmp_done",  32'(done),       32'(active != 0 && rel == END_REL));
    chk("cmp_a_out", 32'(a_out),      32'(ea));
    chk("cmp_b_out", 32'(b_out),      32'(eb));
  end

  // Bench-side output-stationary array driven by the DUT's skewed lanes.
  int acc [N][N];
  int ar  [N][N];
  int br  [N][N];
  int ain [N][N];
  int bin [N][N];
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ain[i][j] = (j == 0) ? int'($signed(a_out[i*8 +: 8])) : ar[i][j-1];
        bin[i][j] = (i == 0) ? int'($signed(b_out[j*8 +: 8])) : br[i-1][j];
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (acc_clr) begin
          acc[i][j] = 0; ar[i][j] = 0; br[i][j] = 0;
        end else begin
          acc[i][j] += ain[i][j] * bin[i][j];
          ar[i][j] = ain[i][j];
          br[i][j] = bin[i][j];
        end
      end
    end
  end

  int clr_at, feed_cnt, done_at, done_cnt;
  logic [N*8-1:0] a_hist [16];
  logic [N*8-1:0] b_hist [16];

  task automatic wr(input logic sel, input int idx, input int k, input logic [7:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_sel = sel; wr_idx = 2'(idx); wr_k = 2'(k); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // wr_c: 0 = write together with start, c>0 = write during cycle c; st_c/rst_c likewise.
  task automatic run_seq(input int wr_c, input logic ws, input int wi, input int wk,
                         input logic [7:0] wd, input int st_c, input int rst_c);
    clr_at = -1; feed_cnt = 0; done_at = -1; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    if (wr_c == 0) begin
      wr_en = 1'b1; wr_sel = ws; wr_idx = 2'(wi); wr_k = 2'(wk); wr_data = wd;
    end
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (acc_clr && clr_at < 0) clr_at = c;
      if (feed_valid && feed_cnt < 16) begin
        a_hist[feed_cnt] = a_out;
        b_hist[feed_cnt] = b_out;
        feed_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      wr_en = 1'b0; start = 1'b0;
      if (c == wr_c) begin
        wr_en = 1'b1; wr_sel = ws; wr_idx = 2'(wi); wr_k = 2'(wk); wr_data = wd;
      end
      if (c == st_c) start = 1'b1;
      if (c == rst_c) begin
        #2 rst = 1'b0;
        #1;
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_feed", 32'(feed_valid), 32'd0);
        chk("rst_async_a",    32'(a_out), 32'd0);
        chk("rst_async_b",    32'(b_out), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        break;
      end
    end
    wr_en = 1'b0; start = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy",    32'(busy), 32'd0);
    chk("reset_acc_clr", 32'(acc_clr), 32'd0);
    chk("reset_feed",    32'(feed_valid), 32'd0);
    chk("reset_done",    32'(done), 32'd0);
    chk("reset_a_out",   32'(a_out), 32'd0);
    chk("reset_b_out",   32'(b_out), 32'd0);
    #1 rst = 1'b1;

    // A = identity, B[k][j] = 4k+j+1
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++)
        wr(1'b0, i, k, (i == k) ? 8'd1 : 8'd0);
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++)
        wr(1'b1, j, k, 8'(4*k + j + 1));
    run_seq(-1, 1'b0, 0, 0, 8'h00, -1, -1);
    chk("ident_clr_at",   32'(clr_at), 32'd1);
    chk("ident_feed_cnt", 32'(feed_cnt), 32'd7);
    chk("ident_done_at",  32'(done_at), 32'd13);
    chk("ident_done_cnt", 32'(done_cnt), 32'd1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("c_eq_b_%0d%0d", i, j), 32'(acc[i][j]), 32'(4*i + j + 1));

    // A[i][k] = 10i+k; write of A[0][0] during FEED must be dropped
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++)
        wr(1'b0, i, k, 8'(10*i + k));
    run_seq(4, 1'b0, 0, 0, 8'h7F, -1, -1);
    chk("a_out_t3", 32'(a_hist[3]), {8'd30, 8'd21, 8'd12, 8'd3});
    chk("a_out_t0", 32'(a_hist[0]), 32'd0);

    // replay with start pulsed during DRAIN
    run_seq(-1, 1'b0, 0, 0, 8'h00, 10, -1);
    chk("replay_a00",    32'(a_hist[0][7:0]), 32'd0);
    chk("replay_a_t3",   32'(a_hist[3]), {8'd30, 8'd21, 8'd12, 8'd3});
    chk("drain_start_done_cnt", 32'(done_cnt), 32'd1);
    chk("drain_start_idle", 32'(busy), 32'd0);

    // reset on FEED cycle 2, then a full sequence from preserved buffers
    run_seq(-1, 1'b0, 0, 0, 8'h00, -1, 4);
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    run_seq(-1, 1'b0, 0, 0, 8'h00, -1, -1);
    chk("post_rst_clr_at",   32'(clr_at), 32'd1);
    chk("post_rst_feed_cnt", 32'(feed_cnt), 32'd7);
    chk("post_rst_done_at",  32'(done_at), 32'd13);
    chk("post_rst_a_t3",     32'(a_hist[3]), {8'd30, 8'd21, 8'd12, 8'd3});

    // start coincident with write of B[3][3] = -128
    run_seq(0, 1'b1, 3, 3, 8'h80, -1, -1);
    chk("same_cycle_b3_t6", 32'(b_hist[6][31:24]), 32'h80);
    chk("same_cycle_done",  32'(done_cnt), 32'd1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
